// File: rtl/tt_board_pkg.sv
// Shared constants and the reset/enable sequencer phase type for the TinyTapeout board harness.
package tt_board_pkg;

    localparam int   UI_W_DEF        = 8;
    localparam int   UO_W_DEF        = 8;
    localparam int   UIO_W_DEF       = 8;
    localparam int   SYNC_STAGES_DEF = 2;
    localparam logic UART_IDLE       = 1'b1;

    typedef enum logic [1:0] {
        PH_RESET   = 2'd0,
        PH_STRETCH = 2'd1,
        PH_RUN     = 2'd2
    } phase_e;

    // Counter width that stays legal when the range collapses to a single value.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/tt_sync_chain.sv
// Multi-flop synchroniser with asynchronous active-low clear; one instance per
// asynchronous input group (ui, uio, usb_rx, halt, reset release).
module tt_sync_chain #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [STAGES];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) stage_q[gi] <= '0;
                else        stage_q[gi] <= d;
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) stage_q[gi] <= '0;
                else        stage_q[gi] <= stage_q[gi-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/tt_board_harness.sv
// Board-side harness for a TinyTapeout-style user design: clock division with halt,
// reset sync/stretch, enable sequencing, input synchronisers, uio tristates, UART pins, heartbeat.
module tt_board_harness
    import tt_board_pkg::*;
#(
    parameter int UI_W        = UI_W_DEF,
    parameter int UO_W        = UO_W_DEF,
    parameter int UIO_W       = UIO_W_DEF,
    parameter int DIV         = 2,
    parameter int RST_HOLD    = 16,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TX_SEL      = 6,
    parameter int RX_SEL      = 7,
    parameter bit RX_EN       = 1'b1,
    parameter int HB_LOG2     = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt,
    input  logic [UI_W-1:0]  ui_pins,
    output logic [UO_W-1:0]  uo_pins,
    inout  wire  [UIO_W-1:0] uio_pins,
    input  logic             usb_rx,
    output logic             usb_tx,
    output logic             led_hb,
    output logic             dut_clk,
    output logic             dut_rst_n,
    output logic             dut_ena,
    output logic [UI_W-1:0]  dut_ui_in,
    input  logic [UO_W-1:0]  dut_uo_out,
    output logic [UIO_W-1:0] dut_uio_in,
    input  logic [UIO_W-1:0] dut_uio_out,
    input  logic [UIO_W-1:0] dut_uio_oe
);

    localparam int HALF = DIV / 2;
    localparam int PH_W = cnt_width(HALF);
    localparam int ST_W = cnt_width(RST_HOLD + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(RST_HOLD);

    if ((DIV < 2) || (DIV % 2 != 0)) begin : g_bad_div
        $error("tt_board_harness: DIV must be even and >= 2");
    end
    if ((TX_SEL >= UIO_W) || (RX_SEL >= UIO_W)) begin : g_bad_sel
        $error("tt_board_harness: TX_SEL/RX_SEL out of uio range");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("tt_board_harness: SYNC_STAGES must be >= 2");
    end
    if (RST_HOLD < 1) begin : g_bad_hold
        $error("tt_board_harness: RST_HOLD must be >= 1");
    end

    logic             rst_s;
    logic             halt_s;
    logic [UIO_W-1:0] uio_mux;

    // Reset release is always two flops deep regardless of SYNC_STAGES.
    tt_sync_chain #(.W(1), .STAGES(2)) u_rst_sync (
        .clk(clk), .rst_n(rst_n), .d(1'b1), .q(rst_s)
    );
    tt_sync_chain #(.W(1), .STAGES(SYNC_STAGES)) u_halt_sync (
        .clk(clk), .rst_n(rst_n), .d(halt), .q(halt_s)
    );
    tt_sync_chain #(.W(UI_W), .STAGES(SYNC_STAGES)) u_ui_sync (
        .clk(clk), .rst_n(rst_n), .d(ui_pins), .q(dut_ui_in)
    );

    always_comb begin
        uio_mux = uio_pins;
        if (RX_EN) uio_mux[RX_SEL] = usb_rx;
    end

    tt_sync_chain #(.W(UIO_W), .STAGES(SYNC_STAGES)) u_uio_sync (
        .clk(clk), .rst_n(rst_n), .d(uio_mux), .q(dut_uio_in)
    );

    logic [PH_W-1:0] ph_q, ph_d;
    logic            dut_clk_q, dut_clk_d;
    logic            toggle;

    // A halt only parks the clock once it is low, so the high half always completes.
    always_comb begin
        ph_d      = ph_q;
        dut_clk_d = dut_clk_q;
        toggle    = 1'b0;
        if (!rst_s) begin
            ph_d      = '0;
            dut_clk_d = 1'b0;
        end else if (halt_s && !dut_clk_q) begin
            ph_d = '0;
        end else if (ph_q == PH_LAST) begin
            ph_d      = '0;
            toggle    = 1'b1;
            dut_clk_d = ~dut_clk_q;
        end else begin
            ph_d = ph_q + 1'b1;
        end
    end

    logic [ST_W-1:0] stretch_q, stretch_d;

    always_comb begin
        stretch_d = stretch_q;
        if (!rst_s)                 stretch_d = '0;
        else if (stretch_q != ST_MAX) stretch_d = stretch_q + 1'b1;
    end

    phase_e phase_q, phase_d;
    logic   dut_rst_n_q, dut_rst_n_d;
    logic   dut_ena_q, dut_ena_d;

    // Release reset only on a falling dut_clk so the DUT sees a full low half first.
    always_comb begin
        phase_d     = phase_q;
        dut_rst_n_d = dut_rst_n_q;
        dut_ena_d   = dut_ena_q;
        case (phase_q)
            PH_RESET: begin
                if (rst_s) phase_d = PH_STRETCH;
            end
            PH_STRETCH: begin
                if ((stretch_d == ST_MAX) && toggle && dut_clk_q) begin
                    phase_d     = PH_RUN;
                    dut_rst_n_d = 1'b1;
                end
            end
            PH_RUN: begin
                if (toggle && !dut_clk_q) dut_ena_d = 1'b1;
            end
            default: phase_d = PH_RESET;
        endcase
        if (!rst_s) begin
            phase_d     = PH_RESET;
            dut_rst_n_d = 1'b0;
            dut_ena_d   = 1'b0;
        end
    end

    logic [HB_LOG2-1:0] hb_q, hb_d;
    logic               led_q, led_d;

    always_comb begin
        hb_d  = hb_q + 1'b1;
        led_d = (&hb_q) ? ~led_q : led_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q        <= '0;
            dut_clk_q   <= 1'b0;
            stretch_q   <= '0;
            phase_q     <= PH_RESET;
            dut_rst_n_q <= 1'b0;
            dut_ena_q   <= 1'b0;
            hb_q        <= '0;
            led_q       <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            dut_clk_q   <= dut_clk_d;
            stretch_q   <= stretch_d;
            phase_q     <= phase_d;
            dut_rst_n_q <= dut_rst_n_d;
            dut_ena_q   <= dut_ena_d;
            hb_q        <= hb_d;
            led_q       <= led_d;
        end
    end

    assign dut_clk   = dut_clk_q;
    assign dut_rst_n = dut_rst_n_q;
    assign dut_ena   = dut_ena_q;
    assign led_hb    = led_q;
    assign uo_pins   = dut_uo_out;
    assign usb_tx    = dut_uio_oe[TX_SEL] ? dut_uio_out[TX_SEL] : UART_IDLE;

    for (genvar gi = 0; gi < UIO_W; gi++) begin : g_uio_tri
        assign uio_pins[gi] = dut_uio_oe[gi] ? dut_uio_out[gi] : 1'bz;
    end

endmodule
